// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU and for the ALU sharing arbiter.
//   - ALU opcode encodings (4-bit). Any encoding not listed here is
//     undefined and makes the ALU return zero.
//   - arb_state_t: state encoding of the arbiter/sequencer FSM.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  // Opcode map. The gaps (0111, 1001, 1011, 1101-1111) are left undefined
  // on purpose so that they can be assigned to future operations.
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_EQ  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'b1010;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b1100;

  // Arbiter sequencing: wait for a request, run the ALU, hand back result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// alu
// Purely combinational ALU shared by the execution-side clients.
// Ports:
//   SrcA, SrcB  : operands (DATA_WIDTH)
//   ALUControl  : operation code, encodings from alu_pkg (OPCODE_LENGTH)
//   ALUResult   : result (DATA_WIDTH); zero for undefined opcodes
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] ALUControl,
  output logic [DATA_WIDTH-1:0]    ALUResult
);

  // Shifts only ever look at the low five bits of operand B.
  logic [4:0] shamt;
  assign shamt = SrcB[4:0];

  // Operation decode. Comparisons produce a zero-extended 0/1; SRA and SLT
  // treat the operands as two's complement.
  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_AND: ALUResult = SrcA & SrcB;
      ALU_OR:  ALUResult = SrcA | SrcB;
      ALU_ADD: ALUResult = SrcA + SrcB;
      ALU_SLL: ALUResult = SrcA << shamt;
      ALU_XOR: ALUResult = SrcA ^ SrcB;
      ALU_SRL: ALUResult = SrcA >> shamt;
      ALU_SUB: ALUResult = SrcA - SrcB;
      ALU_EQ:  ALUResult = (SrcA == SrcB) ? DATA_WIDTH'(1) : '0;
      ALU_SRA: ALUResult = $signed(SrcA) >>> shamt;
      ALU_SLT: ALUResult = ($signed(SrcA) < $signed(SrcB)) ? DATA_WIDTH'(1) : '0;
      default: ALUResult = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Round-robin arbiter/sequencer letting NUM_REQ requesters share a single
// alu instance. One operation is in flight at a time:
//   IDLE: grant one valid requester, latch its operands
//   EXEC: ALU works on the latched operands, result is registered
//   RESP: result is offered to the owner until it accepts it
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid/req_ready   : per-requester operation handshake (ready one-hot)
//   req_srca/req_srcb     : packed per-requester operands, slice i at i*DATA_WIDTH
//   req_op                : packed per-requester opcodes, slice i at i*OPCODE_LENGTH
//   rsp_valid/rsp_ready   : per-requester response handshake (valid one-hot)
//   rsp_result            : shared result bus, valid while any rsp_valid bit is set
//   busy                  : high whenever the FSM is not in IDLE
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
  input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_result,
  output logic                             busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  // Round-robin pick: first set bit searching upward from last+1, wrapping.
  // Callers only use the result when at least one bit is set.
  function automatic logic [IDX_W-1:0] rrPick(
    input logic [NUM_REQ-1:0] valid,
    input logic [IDX_W-1:0]   last
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last) + off) % NUM_REQ);
      if (!found && valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  arb_state_t state_q, state_d;
  logic [IDX_W-1:0]         last_grant_q, last_grant_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [DATA_WIDTH-1:0]    opa_q, opa_d;
  logic [DATA_WIDTH-1:0]    opb_q, opb_d;
  logic [OPCODE_LENGTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0]    res_q, res_d;

  logic [IDX_W-1:0]         winner;
  logic [DATA_WIDTH-1:0]    aluResult;

  // Unpack the flat request buses so the winner can index them directly.
  logic [DATA_WIDTH-1:0]    srcaArr [NUM_REQ];
  logic [DATA_WIDTH-1:0]    srcbArr [NUM_REQ];
  logic [OPCODE_LENGTH-1:0] opArr   [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign srcaArr[g] = req_srca[g*DATA_WIDTH +: DATA_WIDTH];
    assign srcbArr[g] = req_srcb[g*DATA_WIDTH +: DATA_WIDTH];
    assign opArr[g]   = req_op[g*OPCODE_LENGTH +: OPCODE_LENGTH];
  end

  assign winner = rrPick(req_valid, last_grant_q);

  // The ALU sees only the latched operands, so requesters may change or
  // drop their inputs as soon as they have been granted.
  alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_alu (
    .SrcA      (opa_q),
    .SrcB      (opb_q),
    .ALUControl(op_q),
    .ALUResult (aluResult)
  );

  // State and datapath registers. After reset last_grant points at the
  // highest index so that requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_IDX;
      owner_q      <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      op_q         <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      op_q         <= op_d;
      res_q        <= res_d;
    end
  end

  // Next-state and handshake logic. req_ready is gated by reset because the
  // IDLE grant is combinational and must read zero while reset is held.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    op_d         = op_q;
    res_d        = res_q;
    req_ready    = '0;
    rsp_valid    = '0;

    unique case (state_q)
      IDLE: begin
        if (!reset && (|req_valid)) begin
          req_ready[winner] = 1'b1;
          opa_d             = srcaArr[winner];
          opb_d             = srcbArr[winner];
          op_d              = opArr[winner];
          owner_d           = winner;
          state_d           = EXEC;
        end
      end
      EXEC: begin
        res_d   = aluResult;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign rsp_result = res_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Self-checking bench for alu_share_arbiter with three requesters. Expected
// results come from an independent ALU model and travel through a
// scoreboard queue from grant time to response time.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int OW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_srca;
  logic [NR*DW-1:0]  req_srcb;
  logic [NR*OW-1:0]  req_op;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [DW-1:0]     rsp_result;
  logic              busy;

  typedef struct {
    int          owner;
    logic [DW-1:0] res;
  } exp_t;

  exp_t sb[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  alu_share_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .OPCODE_LENGTH(OW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_srca  (req_srca),
    .req_srcb  (req_srcb),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .busy      (busy)
  );

  // Reference ALU written independently of the RTL (SRA built by hand).
  function automatic logic [DW-1:0] modelAlu(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b,
                                             input logic [OW-1:0] op);
    logic [DW-1:0] r;
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a << sh;
      4'b0100: r = a ^ b;
      4'b0101: r = a >> sh;
      4'b0110: r = a - b;
      4'b1000: r = (a == b) ? 32'd1 : 32'd0;
      4'b1010: begin
        r = a >> sh;
        if (a[DW-1] && sh != 0) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      4'b1100: begin
        if (a[DW-1] != b[DW-1]) r = a[DW-1] ? 32'd1 : 32'd0;
        else                    r = (a < b) ? 32'd1 : 32'd0;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [NR-1:0] oneHot(input int i);
    logic [NR-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Present an operation on requester i.
  task automatic setReq(input int i, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [OW-1:0] op);
    req_srca[i*DW +: DW] = a;
    req_srcb[i*DW +: DW] = b;
    req_op[i*OW +: OW]   = op;
    req_valid[i]         = 1'b1;
  endtask

  task automatic pushExp(input int i, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [OW-1:0] op);
    exp_t e;
    e.owner = i;
    e.res   = modelAlu(a, b, op);
    sb.push_back(e);
  endtask

  task automatic popExp(output exp_t e, output bit ok);
    ok      = (sb.size() != 0);
    e.owner = 0;
    e.res   = '0;
    if (ok) e = sb.pop_front();
  endtask

  task automatic pulseReset();
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '0;
    rsp_ready = '0;
    req_srca  = '0;
    req_srcb  = '0;
    req_op    = '0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    nCompared++;
    if (req_ready !== '0) begin nMismatched++; $display("[TB] FAIL reset_req_ready: got %b want 000", req_ready); end
    nCompared++;
    if (rsp_valid !== '0) begin nMismatched++; $display("[TB] FAIL reset_rsp_valid: got %b want 000", rsp_valid); end
    nCompared++;
    if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    nCompared++;
    if (rsp_result !== '0) begin nMismatched++; $display("[TB] FAIL reset_result: got %h want 0", rsp_result); end
    reset = 1'b0;
    @(negedge clk);
    nCompared++;
    if (req_ready !== '0 || busy !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL idle_no_req: ready %b busy %b want 000/0", req_ready, busy);
    end
  endtask

  task automatic test_single_add();
    exp_t e;
    bit   ok;
    rsp_ready = '1;
    setReq(0, 32'd5, 32'd7, ALU_ADD);
    #1;
    nCompared++;
    if (req_ready !== 3'b001) begin nMismatched++; $display("[TB] FAIL add_grant: got %b want 001", req_ready); end
    pushExp(0, 32'd5, 32'd7, ALU_ADD);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    nCompared++;
    if (busy !== 1'b1 || req_ready !== '0 || rsp_valid !== '0) begin
      nMismatched++; $display("[TB] FAIL add_exec: busy %b ready %b rspv %b want 1/000/000", busy, req_ready, rsp_valid);
    end
    @(negedge clk);
    popExp(e, ok);
    nCompared++;
    if (!ok) begin nMismatched++; $display("[TB] FAIL add_sb: got empty want entry"); end
    nCompared++;
    if (rsp_valid !== oneHot(e.owner) || busy !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL add_rsp_valid: got %b busy %b want %b/1", rsp_valid, busy, oneHot(e.owner));
    end
    nCompared++;
    if (rsp_result !== e.res) begin nMismatched++; $display("[TB] FAIL add_result: got %h want %h", rsp_result, e.res); end
    @(negedge clk);
    nCompared++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin
      nMismatched++; $display("[TB] FAIL add_back_idle: busy %b rspv %b want 0/000", busy, rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] a [NR];
    logic [DW-1:0] b [NR];
    exp_t e;
    bit   ok;
    int   w;
    pulseReset();
    a[0] = 32'd3;   b[0] = 32'd5;
    a[1] = 32'd100; b[1] = 32'd1;
    a[2] = 32'd0;   b[2] = 32'd1;
    for (int i = 0; i < NR; i++) setReq(i, a[i], b[i], ALU_SUB);
    rsp_ready = '1;
    #1;
    for (int k = 0; k < 6; k++) begin
      w = k % NR;
      nCompared++;
      if (req_ready !== oneHot(w)) begin
        nMismatched++; $display("[TB] FAIL rr_grant[%0d]: got %b want %b", k, req_ready, oneHot(w));
      end
      pushExp(w, a[w], b[w], ALU_SUB);
      @(negedge clk);
      nCompared++;
      if (req_ready !== '0) begin nMismatched++; $display("[TB] FAIL rr_exec_ready[%0d]: got %b want 000", k, req_ready); end
      @(negedge clk);
      popExp(e, ok);
      nCompared++;
      if (!ok || rsp_valid !== oneHot(e.owner) || rsp_result !== e.res) begin
        nMismatched++;
        $display("[TB] FAIL rr_rsp[%0d]: got %b/%h want %b/%h", k, rsp_valid, rsp_result, oneHot(e.owner), e.res);
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_back_pressure();
    exp_t e;
    bit   ok;
    @(negedge clk);
    rsp_ready = '0;
    setReq(1, 32'h8000_0000, 32'h0000_0024, ALU_SRA);
    #1;
    nCompared++;
    if (req_ready !== 3'b010) begin nMismatched++; $display("[TB] FAIL bp_grant: got %b want 010", req_ready); end
    pushExp(1, 32'h8000_0000, 32'h0000_0024, ALU_SRA);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    setReq(0, 32'd1, 32'd1, ALU_ADD);
    #1;
    nCompared++;
    if (req_ready !== '0) begin nMismatched++; $display("[TB] FAIL bp_exec_ready: got %b want 000", req_ready); end
    @(negedge clk);
    rsp_ready = 3'b101;
    popExp(e, ok);
    nCompared++;
    if (!ok) begin nMismatched++; $display("[TB] FAIL bp_sb: got empty want entry"); end
    for (int i = 0; i < 5; i++) begin
      nCompared++;
      if (rsp_valid !== 3'b010 || rsp_result !== e.res || req_ready !== '0 || busy !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL bp_hold[%0d]: rspv %b res %h ready %b busy %b want 010/%h/000/1",
                 i, rsp_valid, rsp_result, req_ready, busy, e.res);
      end
      @(negedge clk);
    end
    rsp_ready = 3'b010;
    @(negedge clk);
    nCompared++;
    if (req_ready !== 3'b001) begin nMismatched++; $display("[TB] FAIL bp_next_grant: got %b want 001", req_ready); end
    pushExp(0, 32'd1, 32'd1, ALU_ADD);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = '1;
    @(negedge clk);
    popExp(e, ok);
    nCompared++;
    if (!ok || rsp_valid !== oneHot(e.owner) || rsp_result !== e.res) begin
      nMismatched++; $display("[TB] FAIL bp_after: got %b/%h want %b/%h", rsp_valid, rsp_result, oneHot(e.owner), e.res);
    end
    @(negedge clk);
  endtask

  task automatic test_ops();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
    exp_t e;
    bit   ok;
    int   r;
    rsp_ready = '1;
    for (int k = 0; k < 18; k++) begin
      r = (k + 2) % NR;
      if (k == 0) begin
        a = 32'hFFFF_FFFF; b = 32'd1; op = ALU_SLT;
      end else if (k == 1) begin
        a = 32'h1234_5678; b = 32'h9ABC_DEF0; op = 4'b1111;
      end else begin
        a  = $urandom;
        b  = $urandom;
        op = OW'(k - 2);
        if (op == ALU_EQ && k[0]) b = a;
      end
      setReq(r, a, b, op);
      #1;
      nCompared++;
      if (req_ready !== oneHot(r)) begin
        nMismatched++; $display("[TB] FAIL ops_grant[%0d]: got %b want %b", k, req_ready, oneHot(r));
      end
      pushExp(r, a, b, op);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      popExp(e, ok);
      nCompared++;
      if (!ok || rsp_valid !== oneHot(e.owner) || rsp_result !== e.res) begin
        nMismatched++;
        $display("[TB] FAIL ops_rsp[%0d] op %b: got %b/%h want %b/%h", k, op, rsp_valid, rsp_result, oneHot(e.owner), e.res);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   ok;
    rsp_ready = '1;
    setReq(1, 32'd7, 32'd8, ALU_ADD);
    #1;
    nCompared++;
    if (req_ready !== 3'b010) begin nMismatched++; $display("[TB] FAIL rm_grant: got %b want 010", req_ready); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    #1;
    nCompared++;
    if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b0 || rsp_result !== '0) begin
      nMismatched++;
      $display("[TB] FAIL rm_outputs: ready %b rspv %b busy %b res %h want all 0", req_ready, rsp_valid, busy, rsp_result);
    end
    setReq(0, 32'd10, 32'd3, ALU_SUB);
    setReq(2, 32'd4, 32'd4, ALU_EQ);
    @(negedge clk);
    nCompared++;
    if (rsp_valid !== '0 || req_ready !== '0) begin
      nMismatched++; $display("[TB] FAIL rm_hold: rspv %b ready %b want 000/000", rsp_valid, req_ready);
    end
    reset = 1'b0;
    #1;
    nCompared++;
    if (req_ready !== 3'b001) begin nMismatched++; $display("[TB] FAIL rm_first_grant: got %b want 001", req_ready); end
    pushExp(0, 32'd10, 32'd3, ALU_SUB);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    popExp(e, ok);
    nCompared++;
    if (!ok || rsp_valid !== oneHot(e.owner) || rsp_result !== e.res) begin
      nMismatched++; $display("[TB] FAIL rm_rsp: got %b/%h want %b/%h", rsp_valid, rsp_result, oneHot(e.owner), e.res);
    end
    @(negedge clk);
    nCompared++;
    if (sb.size() != 0) begin nMismatched++; $display("[TB] FAIL sb_drain: got %0d left want 0", sb.size()); end
  endtask

  // Watchdog so a stuck run still terminates with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_back_pressure();
    test_ops();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one instance of the team's `alu` between `NUM_REQ` independent requesters. Each requester hands over an operation with a valid/ready handshake and receives its result back through a per-requester valid/ready response channel. The block sits between the execution-side clients (for example, the address-generation and multi-cycle helper units) and the single ALU, serialising their operations with fair rotation and full back-pressure.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `DATA_WIDTH`, 32: operand and result width.
- `OPCODE_LENGTH`, 4: ALU operation code width, using the same encoding as `alu`.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input `NUM_REQ`: requester i has an operation pending.
- `req_ready` output `NUM_REQ`: one-hot or zero; the operation is accepted when `req_valid[i] & req_ready[i]`.
- `req_srca` input `NUM_REQ*DATA_WIDTH`: operand A per requester; slice i is `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_srcb` input `NUM_REQ*DATA_WIDTH`: operand B per requester, sliced the same way.
- `req_op` input `NUM_REQ*OPCODE_LENGTH`: operation per requester, sliced the same way.
- `rsp_valid` output `NUM_REQ`: one-hot or zero; result available for requester i.
- `rsp_ready` input `NUM_REQ`: requester i accepts its result.
- `rsp_result` output `DATA_WIDTH`: shared result bus; meaningful only while some `rsp_valid` bit is high.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` bit is set, pick the winner by round-robin: the first set bit searching upward from `last_grant+1`, wrapping modulo `NUM_REQ`.
  - `req_ready[winner]` is 1 combinationally in this cycle only.
  - On the clock edge: latch the winner's A, B and op into `opa_q`, `opb_q` and `op_q`; set `owner_q` to the winner; go to EXEC.
  - If no `req_valid` bit is set, stay in IDLE and keep `req_ready` at 0.
- **EXEC**
  - The ALU is driven only from `opa_q`, `opb_q` and `op_q`.
  - On the clock edge: register `ALUResult` into `res_q`; go to RESP.
- **RESP**
  - `rsp_valid[owner_q]` is 1 and `rsp_result` equals `res_q`.
  - The block holds in RESP until `rsp_ready[owner_q]` is 1.
  - On that edge: set `last_grant` to `owner_q` and go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- `req_ready` is 0 in EXEC and RESP. Requests are never accepted while a transaction is in flight.
- Arithmetic and width rules are those of the ALU:
  - Shift amounts use B[4:0].
  - SRA and SLT are signed.
  - Equal and SLT return 1 or 0, zero-extended.
  - Any undefined opcode (0111, 1001, 1011, 1101–1111) returns 0 and still completes normally with a response.
- `req_valid` dropping without a handshake is legal and has no effect. A requester may re-present a new operation in the cycle after its response handshake.
- Fairness: every continuously asserted `req_valid` is granted within `NUM_REQ` transactions.

## Timing
- Reset values, applied immediately while `reset` is high:
  - State is IDLE and `last_grant` is `NUM_REQ-1`, so requester 0 wins first.
  - `req_ready`, `rsp_valid` and `busy` are all 0.
  - `opa_q`, `opb_q`, `op_q`, `res_q` and `owner_q` are all 0, so `rsp_result` is 0.
- Latency: accept on edge T, EXEC during cycle T+1, `rsp_valid` high in cycle T+2. The earliest response handshake is edge T+2.
- Throughput: at most one operation per 3 cycles with `rsp_ready` tied high; the next grant can occur in the cycle after the response handshake.
- Simultaneous requests in IDLE produce exactly one grant. The losers see `req_ready` at 0 and must hold their inputs.
- Reset asserted mid-transaction: the transaction is dropped with no response, and the first grant after reset goes to requester 0.
- `rsp_result` stays stable for the whole time `rsp_valid` is high.

## Structure
- Shared package `alu_pkg` holds:
  - ALU opcode localparams (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SLL`, `ALU_XOR`, `ALU_SRL`, `ALU_SUB`, `ALU_EQ`, `ALU_SRA`, `ALU_SLT`).
  - The FSM enum `arb_state_t` with values IDLE, EXEC and RESP.
- Exactly one sub-module: the existing `alu`, instantiated once with matching `DATA_WIDTH` and `OPCODE_LENGTH`.
- Round-robin selection is a combinational function inside this block; there is no separate arbiter module.

## Test plan
- Reset release, then requester 0 sends ADD A=5, B=7; `rsp_ready` tied high → `req_ready[0]` high in the request cycle, `rsp_valid[0]` two cycles later with `rsp_result`=12, `busy` high for 2 cycles.
- `NUM_REQ`=3, all requesters continuously valid with SUB ops → grant order 0,1,2,0,1,2, one grant per 3 cycles. Requester 0 with A=3, B=5 gets 0xFFFFFFFE.
- Requester 1 sends SRA A=0x80000000, B=0x24 and holds `rsp_ready`=0 for 5 cycles → `rsp_valid[1]` and `rsp_result`=0xF8000000 stable throughout, `req_ready` stays 0 despite requester 0 being valid; requester 0 is granted in the cycle after the handshake.
- SLT A=0xFFFFFFFF, B=1 → result 1. Opcode 1111 → result 0 and the response still completes.
- `reset` pulsed during EXEC → no `rsp_valid` appears, all outputs are 0 immediately, and the next grant goes to requester 0 even if requester 1 was the last owner.
